// File: rtl/gcd_controller.sv
// Sequencing FSM for the subtractive GCD datapath: start/ready/done handshake,
// subtraction counting and an iteration-limit abort so that zero operands cannot hang.
module gcd_controller #(
  parameter int unsigned       ITER_W   = 16,
  parameter logic [ITER_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a_gt_b,
  input  logic              a_lt_b,
  input  logic              a_eq_b,
  output logic              a_ld,
  output logic              b_ld,
  output logic              a_sel,
  output logic              b_sel,
  output logic              output_en,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {StIdle, StLoad, StCalc, StDone, StErr} state_e;

  state_e            state_q;
  logic [ITER_W-1:0] iter_cnt_q;
  logic              at_limit;

  assign at_limit = (iter_cnt_q == MAX_ITER);
  assign iter_cnt = iter_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      iter_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StLoad;
            iter_cnt_q <= '0;
          end
        end
        StLoad: state_q <= StCalc;
        StCalc: begin
          // Equality wins over the limit so a finished result is never discarded.
          if (a_eq_b) begin
            state_q <= StDone;
          end else if (at_limit) begin
            state_q <= StErr;
          end else if (a_gt_b || a_lt_b) begin
            iter_cnt_q <= iter_cnt_q + ITER_W'(1);
          end else begin
            state_q <= StErr;
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    output_en = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      StIdle: ready = 1'b1;
      StLoad: begin
        busy = 1'b1;
        a_ld = 1'b1;
        b_ld = 1'b1;
      end
      StCalc: begin
        busy = 1'b1;
        if (a_eq_b) begin
          output_en = 1'b1;
        end else if (!at_limit) begin
          if (a_gt_b) begin
            a_ld  = 1'b1;
            a_sel = 1'b1;
          end else if (a_lt_b) begin
            b_ld  = 1'b1;
            b_sel = 1'b1;
          end
        end
      end
      StDone: done = 1'b1;
      StErr: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: two instances (large and small iteration limit), each driving
// a small GCD datapath, checked against an arithmetic reference of subtractive GCD.
module tb_gcd_controller;

  localparam int Max0 = 300;
  localparam int Max1 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in1, in2;
  logic        start     [2];
  logic        a_gt_b    [2];
  logic        a_lt_b    [2];
  logic        a_eq_b    [2];
  logic        a_ld      [2];
  logic        b_ld      [2];
  logic        a_sel     [2];
  logic        b_sel     [2];
  logic        output_en [2];
  logic        ready     [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];
  logic [15:0] iter_cnt  [2];
  logic [15:0] out_val   [2];

  int          checks = 0;
  int          errors = 0;
  int          last_out [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [15:0] a_reg, b_reg, out_reg;

    gcd_controller #(
      .ITER_W  (16),
      .MAX_ITER((k == 0) ? 16'(Max0) : 16'(Max1))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[k]),
      .a_gt_b   (a_gt_b[k]),
      .a_lt_b   (a_lt_b[k]),
      .a_eq_b   (a_eq_b[k]),
      .a_ld     (a_ld[k]),
      .b_ld     (b_ld[k]),
      .a_sel    (a_sel[k]),
      .b_sel    (b_sel[k]),
      .output_en(output_en[k]),
      .ready    (ready[k]),
      .busy     (busy[k]),
      .done     (done[k]),
      .err      (err[k]),
      .iter_cnt (iter_cnt[k])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        a_reg   <= '0;
        b_reg   <= '0;
        out_reg <= '0;
      end else begin
        if (a_ld[k]) a_reg <= a_sel[k] ? a_reg - b_reg : in1;
        if (b_ld[k]) b_reg <= b_sel[k] ? b_reg - a_reg : in2;
        if (output_en[k]) out_reg <= b_reg;
      end
    end

    assign a_gt_b[k]  = a_reg > b_reg;
    assign a_lt_b[k]  = a_reg < b_reg;
    assign a_eq_b[k]  = a_reg == b_reg;
    assign out_val[k] = out_reg;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Subtractive GCD with the abort rule: equality first, then the subtraction limit.
  function automatic void ref_gcd(input int a, input int b, input int max,
                                  output int res, output int n, output bit e);
    n = 0;
    while (a != b && n < max) begin
      if (a > b) a -= b;
      else       b -= a;
      n++;
    end
    e   = (a != b);
    res = e ? 0 : b;
  endfunction

  task automatic run(input int k, input int x, input int y, input bit hold);
    int exp_out, exp_n, cyc, pulses, both;
    bit exp_err, seen;
    ref_gcd(x, y, (k == 0) ? Max0 : Max1, exp_out, exp_n, exp_err);
    if (exp_err) exp_out = last_out[k];
    @(negedge clk);
    check("ready_before_start", 32'(ready[k]), 1);
    in1      = 16'(x);
    in2      = 16'(y);
    start[k] = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (!hold) start[k] = 1'b0;
    check("load_strobes", {28'd0, busy[k], a_ld[k], b_ld[k], a_sel[k] | b_sel[k]}, 32'hE);
    pulses = 0;
    both   = 0;
    seen   = 0;
    while (cyc < exp_n + 16) begin
      if (done[k]) begin
        seen = 1;
        break;
      end
      if (cyc >= 2) begin
        if (a_ld[k] && b_ld[k]) both++;
        if (a_ld[k] || b_ld[k]) pulses++;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(seen), 1);
    check("done_latency", 32'(cyc), 32'(3 + exp_n));
    check("err_flag", 32'(err[k]), 32'(exp_err));
    check("result", 32'(out_val[k]), 32'(exp_out));
    check("iter_cnt", 32'(iter_cnt[k]), 32'(exp_n));
    check("ld_pulses", 32'(pulses), 32'(exp_n));
    check("both_ld_in_calc", 32'(both), 0);
    if (!exp_err) last_out[k] = exp_out;
  endtask

  initial begin
    int nodone;
    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    in1      = '0;
    in2      = '0;
    last_out[0] = 0;
    last_out[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("reset_ready", 32'(ready[k]), 1);
      check("reset_outputs", {23'd0, busy[k], done[k], err[k], a_ld[k], b_ld[k], a_sel[k],
                              b_sel[k], output_en[k]}, 0);
      check("reset_iter", 32'(iter_cnt[k]), 0);
    end

    run(0, 12, 8, 0);
    run(0, 7, 7, 0);
    run(0, 1071, 462, 0);
    run(1, 12, 8, 0);
    run(1, 0, 5, 0);

    // start held high across two computations: each start accepted only from IDLE.
    run(0, 21, 6, 1);
    run(0, 9, 27, 1);
    start[0] = 1'b0;
    @(negedge clk);
    check("idle_after_hold", 32'(ready[0]), 1);
    @(negedge clk);
    check("no_extra_accept", {30'd0, ready[0], busy[0]}, 2);

    // Reset in the second CALC cycle of a long run.
    in1      = 16'd1071;
    in2      = 16'd462;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_run_iter", 32'(iter_cnt[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(ready[0]), 1);
    check("rst_outputs", {23'd0, busy[0], done[0], err[0], a_ld[0], b_ld[0], a_sel[0], b_sel[0],
                          output_en[0]}, 0);
    check("rst_iter", 32'(iter_cnt[0]), 0);
    last_out[0] = 0;
    last_out[1] = 0;
    nodone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0]) nodone++;
    end
    check("no_done_after_rst", 32'(nodone), 0);
    run(0, 12, 8, 0);

    for (int i = 0; i < 12; i++) run(0, $urandom_range(1, 200), $urandom_range(1, 200), 0);
    for (int i = 0; i < 8; i++) run(1, $urandom_range(0, 20), $urandom_range(0, 20), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
